sample_iter: RTL and testbench

- Sample iterator stage of the rasterizer, directly upstream of the sample test / jitter-hash stage.
- Accepts one triangle plus its pixel-aligned bounding box from the bounding-box stage.
- Walks every sample position in the box in raster order (x fastest) at the active subsample step.
- Emits one sample coordinate per cycle with the triangle carried alongside; the downstream hash tree consumes the sample coordinate bits.

---
 rtl/sample_iter_if.sv | 28 ++
 rtl/sample_iter.sv | 115 +++++++++++
 tb/tb_sample_iter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sample_iter_if.sv
// Upstream (R13) and downstream (R14) signal bundle of the sample iterator.
// master = triangle source / sample consumer side, slave = the iterator.
interface sample_iter_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3
);
  logic [VERTS*AXIS*SIGFIG-1:0] tri_R13S;
  logic [4*SIGFIG-1:0]          box_R13S;
  logic                         validTri_R13H;
  logic [3:0]                   subSample_RnnnnU;
  logic                         stall_R14H;
  logic                         halt_RnnnnL;
  logic [VERTS*AXIS*SIGFIG-1:0] tri_R14S;
  logic [2*SIGFIG-1:0]          sample_R14S;
  logic                         validSamp_R14H;
  logic                         lastSamp_R14H;

  modport master (
    output tri_R13S, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    input  halt_RnnnnL, tri_R14S, sample_R14S, validSamp_R14H, lastSamp_R14H
  );

  modport slave (
    input  tri_R13S, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    output halt_RnnnnL, tri_R14S, sample_R14S, validSamp_R14H, lastSamp_R14H
  );
endinterface

// File: rtl/sample_iter.sv
// Sample iterator: walks every sample position of a pixel-aligned bounding box
// in raster order (x fastest) at the selected subsample step, one per cycle.
module sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3
) (
  input logic           clk,
  input logic           rst_n,
  sample_iter_if.slave  bus
);
  localparam int TW = VERTS*AXIS*SIGFIG;

  typedef enum logic {WAIT, TEST} state_t;
  typedef logic signed [SIGFIG:0]   wide_t;
  typedef logic signed [SIGFIG-1:0] coord_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tri_q, tri_nx;
  coord_t          x_q, x_nx, y_q, y_nx;
  coord_t          llx_q, llx_nx, urx_q, urx_nx, ury_q, ury_nx;
  wide_t           step_q, step_nx, step_sel;
  wide_t           x_adv, y_adv;
  coord_t          in_llx, in_lly, in_urx, in_ury;
  logic            degenerate;

  assign in_llx = bus.box_R13S[0*SIGFIG +: SIGFIG];
  assign in_lly = bus.box_R13S[1*SIGFIG +: SIGFIG];
  assign in_urx = bus.box_R13S[2*SIGFIG +: SIGFIG];
  assign in_ury = bus.box_R13S[3*SIGFIG +: SIGFIG];

  assign degenerate = (in_llx > in_urx) || (in_lly > in_ury);

  always_comb begin
    case (bus.subSample_RnnnnU)
      4'b0100: step_sel = wide_t'(1 << (RADIX-1));
      4'b0010: step_sel = wide_t'(1 << (RADIX-2));
      4'b0001: step_sel = wide_t'(1 << (RADIX-3));
      default: step_sel = wide_t'(1 << RADIX);
    endcase
  end

  // One extra bit keeps x+step / y+step from wrapping near the coordinate limit.
  assign x_adv = wide_t'({x_q[SIGFIG-1], x_q}) + step_q;
  assign y_adv = wide_t'({y_q[SIGFIG-1], y_q}) + step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT;
      tri_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      llx_q  <= '0;
      urx_q  <= '0;
      ury_q  <= '0;
      step_q <= '0;
    end else begin
      state  <= state_nx;
      tri_q  <= tri_nx;
      x_q    <= x_nx;
      y_q    <= y_nx;
      llx_q  <= llx_nx;
      urx_q  <= urx_nx;
      ury_q  <= ury_nx;
      step_q <= step_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tri_nx   = tri_q;
    x_nx     = x_q;
    y_nx     = y_q;
    llx_nx   = llx_q;
    urx_nx   = urx_q;
    ury_nx   = ury_q;
    step_nx  = step_q;
    case (state)
      WAIT: begin
        if (bus.validTri_R13H && !degenerate) begin
          tri_nx   = bus.tri_R13S;
          llx_nx   = in_llx;
          urx_nx   = in_urx;
          ury_nx   = in_ury;
          step_nx  = step_sel;
          x_nx     = in_llx;
          y_nx     = in_lly;
          state_nx = TEST;
        end
      end
      TEST: begin
        if (!bus.stall_R14H) begin
          if (x_adv <= wide_t'({urx_q[SIGFIG-1], urx_q})) begin
            x_nx = x_adv[SIGFIG-1:0];
          end else begin
            x_nx = llx_q;
            y_nx = y_adv[SIGFIG-1:0];
            if (y_adv > wide_t'({ury_q[SIGFIG-1], ury_q}))
              state_nx = WAIT;
          end
        end
      end
      default: state_nx = WAIT;
    endcase
  end

  assign bus.halt_RnnnnL    = (state == WAIT);
  assign bus.validSamp_R14H = (state == TEST);
  assign bus.tri_R14S       = tri_q;
  assign bus.sample_R14S    = {y_q, x_q};
  assign bus.lastSamp_R14H  = (state == TEST)
                            && (x_adv > wide_t'({urx_q[SIGFIG-1], urx_q}))
                            && (y_adv > wide_t'({ury_q[SIGFIG-1], ury_q}));
endmodule

// File: tb/tb_sample_iter.sv
// Directed bench for sample_iter: walks, stall, degenerate boxes, back-to-back
// boxes and asynchronous reset in the middle of a box.
module tb_sample_iter;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int TW     = VERTS*AXIS*SIGFIG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  sample_iter_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS)) bus ();

  sample_iter #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [4*SIGFIG-1:0] mkbox(input int llx, input int lly,
                                                input int urx, input int ury);
    return {ury[SIGFIG-1:0], urx[SIGFIG-1:0], lly[SIGFIG-1:0], llx[SIGFIG-1:0]};
  endfunction

  function automatic logic [2*SIGFIG-1:0] mksamp(input int x, input int y);
    return {y[SIGFIG-1:0], x[SIGFIG-1:0]};
  endfunction

  function automatic logic [TW-1:0] mktri(input logic [SIGFIG-1:0] seed);
    logic [TW-1:0] t;
    for (int i = 0; i < VERTS*AXIS; i++)
      t[i*SIGFIG +: SIGFIG] = seed + SIGFIG'(i * 24'h010101);
    return t;
  endfunction

  // Called at a negedge with the block idle; returns at a negedge after the box drains.
  task automatic walk(input string tag, input int llx, input int lly, input int urx,
                      input int ury, input logic [3:0] sub, input logic [TW-1:0] tv,
                      input int stall_at, input int stall_len);
    int   step;
    int   k;
    logic lst;
    step = (sub == 4'b0100) ? 512 : (sub == 4'b0010) ? 256 :
           (sub == 4'b0001) ? 128 : 1024;
    chk({tag, "/halt_idle"}, TW'(bus.halt_RnnnnL), TW'(1));
    bus.tri_R13S         = tv;
    bus.box_R13S         = mkbox(llx, lly, urx, ury);
    bus.subSample_RnnnnU = sub;
    bus.validTri_R13H    = 1'b1;
    @(negedge clk);
    // Scramble the R13 inputs while busy; they must be ignored.
    bus.validTri_R13H    = 1'b0;
    bus.tri_R13S         = '1;
    bus.box_R13S         = mkbox(0, 0, 0, 0);
    bus.subSample_RnnnnU = 4'b0001;
    k = 0;
    for (int y = lly; y <= ury; y += step) begin
      for (int x = llx; x <= urx; x += step) begin
        lst = (x + step > urx) && (y + step > ury);
        for (int h = 0; h <= ((k == stall_at) ? stall_len : 0); h++) begin
          chk($sformatf("%s/valid%0d", tag, k), TW'(bus.validSamp_R14H), TW'(1));
          chk($sformatf("%s/samp%0d", tag, k), TW'(bus.sample_R14S), TW'(mksamp(x, y)));
          chk($sformatf("%s/last%0d", tag, k), TW'(bus.lastSamp_R14H), TW'(lst));
          chk($sformatf("%s/halt%0d", tag, k), TW'(bus.halt_RnnnnL), TW'(0));
          chk($sformatf("%s/tri%0d", tag, k), bus.tri_R14S, tv);
          bus.stall_R14H = (k == stall_at) && (h < stall_len);
          @(negedge clk);
        end
        k++;
      end
    end
    bus.stall_R14H = 1'b0;
    chk({tag, "/valid_end"}, TW'(bus.validSamp_R14H), TW'(0));
    chk({tag, "/halt_end"}, TW'(bus.halt_RnnnnL), TW'(1));
    chk({tag, "/last_end"}, TW'(bus.lastSamp_R14H), TW'(0));
  endtask

  initial begin
    bus.tri_R13S         = '0;
    bus.box_R13S         = '0;
    bus.validTri_R13H    = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    bus.stall_R14H       = 1'b0;

    #12;
    chk("rst/halt", TW'(bus.halt_RnnnnL), TW'(1));
    chk("rst/valid", TW'(bus.validSamp_R14H), TW'(0));
    chk("rst/last", TW'(bus.lastSamp_R14H), TW'(0));
    chk("rst/samp", TW'(bus.sample_R14S), TW'(0));
    chk("rst/tri", bus.tri_R14S, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    walk("px1", 0, 0, 2048, 1024, 4'b1000, mktri(24'h100000), -1, 0);
    walk("sub", 1024, 1024, 2048, 2048, 4'b0100, mktri(24'h200000), -1, 0);
    walk("stall", 0, 0, 2048, 1024, 4'b1000, mktri(24'h300000), 1, 3);
    walk("single", -512, -512, -512, -512, 4'b1000, mktri(24'h400000), -1, 0);

    // Degenerate box: dropped, block stays idle, stall in WAIT is harmless.
    bus.box_R13S      = mkbox(1024, 0, 0, 0);
    bus.tri_R13S      = mktri(24'h500000);
    bus.validTri_R13H = 1'b1;
    bus.stall_R14H    = 1'b1;
    @(negedge clk);
    bus.validTri_R13H = 1'b0;
    bus.stall_R14H    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("degen/valid%0d", i), TW'(bus.validSamp_R14H), TW'(0));
      chk($sformatf("degen/halt%0d", i), TW'(bus.halt_RnnnnL), TW'(1));
      @(negedge clk);
    end

    // Back-to-back single-sample boxes with valid held high.
    bus.box_R13S      = mkbox(0, 0, 0, 0);
    bus.tri_R13S      = mktri(24'h600000);
    bus.validTri_R13H = 1'b1;
    @(negedge clk);
    chk("b2b/valid0", TW'(bus.validSamp_R14H), TW'(1));
    chk("b2b/tri0", bus.tri_R14S, mktri(24'h600000));
    chk("b2b/last0", TW'(bus.lastSamp_R14H), TW'(1));
    bus.box_R13S = mkbox(3072, 2048, 3072, 2048);
    bus.tri_R13S = mktri(24'h700000);
    @(negedge clk);
    chk("b2b/bubble", TW'(bus.validSamp_R14H), TW'(0));
    chk("b2b/halt_bubble", TW'(bus.halt_RnnnnL), TW'(1));
    @(negedge clk);
    bus.validTri_R13H = 1'b0;
    chk("b2b/valid1", TW'(bus.validSamp_R14H), TW'(1));
    chk("b2b/tri1", bus.tri_R14S, mktri(24'h700000));
    chk("b2b/samp1", TW'(bus.sample_R14S), TW'(mksamp(3072, 2048)));
    @(negedge clk);
    chk("b2b/valid_end", TW'(bus.validSamp_R14H), TW'(0));

    // Asynchronous reset in the middle of a large box.
    bus.box_R13S         = mkbox(0, 0, 8192, 8192);
    bus.tri_R13S         = mktri(24'h800000);
    bus.subSample_RnnnnU = 4'b0001;
    bus.validTri_R13H    = 1'b1;
    @(negedge clk);
    bus.validTri_R13H = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid/valid_before", TW'(bus.validSamp_R14H), TW'(1));
    chk("rmid/samp_before", TW'(bus.sample_R14S), TW'(mksamp(384, 0)));
    #2 rst_n = 1'b0;
    #1;
    chk("rmid/valid_async", TW'(bus.validSamp_R14H), TW'(0));
    chk("rmid/halt_async", TW'(bus.halt_RnnnnL), TW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rmid/valid%0d", i), TW'(bus.validSamp_R14H), TW'(0));
      chk($sformatf("rmid/halt%0d", i), TW'(bus.halt_RnnnnL), TW'(1));
      chk($sformatf("rmid/samp%0d", i), TW'(bus.sample_R14S), TW'(0));
      chk($sformatf("rmid/tri%0d", i), bus.tri_R14S, '0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
